// File: rtl/axis_stream_packer.sv
// AXI-Stream byte packer: optional LSB-aligned header beat followed by MSB-aligned partial-keep
// data beats, repacked so that every output beat is full except the tlast beat.
module axis_stream_packer #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter bit HDR_EN       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hdr_valid,
  input  logic [DATA_WD-1:0]      hdr_data,
  input  logic [DATA_BYTE_WD-1:0] hdr_keep,
  output logic                    hdr_ready,
  input  logic                    s_valid,
  input  logic [DATA_WD-1:0]      s_data,
  input  logic [DATA_BYTE_WD-1:0] s_keep,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [DATA_WD-1:0]      m_data,
  output logic [DATA_BYTE_WD-1:0] m_keep,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    keep_err
);

  localparam int CW = BYTE_CNT_WD + 2;
  localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam state_t IDLE_ST = HDR_EN ? ST_HDR : ST_DATA;

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + {{(CW-1){1'b0}}, k[i]};
    end
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[DATA_BYTE_WD-1-i] = (CW'(i) < cnt);
    end
    return m;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] low_mask(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[i] = (CW'(i) < cnt);
    end
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_expand(input logic [DATA_BYTE_WD-1:0] m);
    logic [DATA_WD-1:0] e;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      e[8*i +: 8] = {8{m[i]}};
    end
    return e;
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [CW-1:0]           rc_q, rc_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WD-1:0]      m_data_q, m_data_d;
  logic [DATA_BYTE_WD-1:0] m_keep_q, m_keep_d;
  logic                    m_last_q, m_last_d;
  logic                    keep_err_q, keep_err_d;

  logic                    out_free;
  logic [CW-1:0]           s_cnt, hdr_cnt, tot;
  logic [DATA_WD-1:0]      s_masked, hdr_res;
  logic [2*DATA_WD-1:0]    cat;
  logic                    s_keep_bad, hdr_keep_bad;

  // Residue bytes beyond rc are always zero, so OR-ing in the shifted input forms {residue,in}.
  always_comb begin
    out_free     = !m_valid_q || m_ready;
    s_cnt        = popcount(s_keep);
    hdr_cnt      = popcount(hdr_keep);
    tot          = rc_q + s_cnt;
    s_masked     = s_data & byte_expand(top_mask(s_cnt));
    cat          = {res_q, {DATA_WD{1'b0}}} | ({s_masked, {DATA_WD{1'b0}}} >> {rc_q, 3'b000});
    hdr_res      = (hdr_data & byte_expand(low_mask(hdr_cnt))) << {W_C - hdr_cnt, 3'b000};
    s_keep_bad   = (s_keep != top_mask(s_cnt));
    hdr_keep_bad = (hdr_keep != low_mask(hdr_cnt));
  end

  // Next-state, residue update and output-register load.
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    rc_d       = rc_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    keep_err_d = keep_err_q;
    hdr_ready  = 1'b0;
    s_ready    = 1'b0;
    if (out_free) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    case (state_q)
      ST_HDR: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          res_d      = hdr_res;
          rc_d       = hdr_cnt;
          keep_err_d = keep_err_q | hdr_keep_bad;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        s_ready = out_free;
        if (s_valid && out_free) begin
          keep_err_d = keep_err_q | s_keep_bad;
          if (s_last && (tot <= W_C)) begin
            m_valid_d = 1'b1;
            m_data_d  = cat[2*DATA_WD-1 -: DATA_WD];
            m_keep_d  = top_mask(tot);
            m_last_d  = 1'b1;
            res_d     = '0;
            rc_d      = '0;
            state_d   = IDLE_ST;
          end else if (tot >= W_C) begin
            // A last beat that overflows one output beat leaves residue for FLUSH.
            m_valid_d = 1'b1;
            m_data_d  = cat[2*DATA_WD-1 -: DATA_WD];
            m_keep_d  = '1;
            m_last_d  = 1'b0;
            res_d     = cat[DATA_WD-1:0];
            rc_d      = tot - W_C;
            state_d   = s_last ? ST_FLUSH : ST_DATA;
          end else begin
            res_d = cat[2*DATA_WD-1 -: DATA_WD];
            rc_d  = tot;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = res_q;
          m_keep_d  = top_mask(rc_q);
          m_last_d  = 1'b1;
          res_d     = '0;
          rc_d      = '0;
          state_d   = IDLE_ST;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = IDLE_ST;
      end
    endcase
  end

  // State, residue and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_ST;
      res_q      <= '0;
      rc_q       <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      keep_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      rc_q       <= rc_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      keep_err_q <= keep_err_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_keep   = m_keep_q;
  assign m_last   = m_last_q;
  assign keep_err = keep_err_q;

endmodule
